// File: rtl/trig_lut_deg.sv
// Whole-degree sine/cosine generator, outputs scaled by 100, one-cycle registered latency.
// Optional macro TRIG_VALID_EN adds in_valid/out_valid qualification of the output registers.
module trig_lut_deg #(
    parameter int unsigned ANGLE_W = 7,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned SCALE   = 100
) (
    input  logic               clk,
    input  logic               reset,
`ifdef TRIG_VALID_EN
    input  logic               in_valid,
    output logic               out_valid,
`endif
    input  logic [ANGLE_W-1:0] angle,
    output logic [OUT_W-1:0]   sin_out,
    output logic [OUT_W-1:0]   cos_out
);

    localparam int unsigned IDX_W = 7;
    localparam int unsigned EXT_W = 8;

    // Quarter-wave table: round(100*sin(k deg)), k = 0..90, ties away from zero.
    localparam logic [IDX_W-1:0] QTAB [0:90] = '{
        7'd0,   7'd2,   7'd3,   7'd5,   7'd7,   7'd9,   7'd10,  7'd12,  7'd14,  7'd16,
        7'd17,  7'd19,  7'd21,  7'd22,  7'd24,  7'd26,  7'd28,  7'd29,  7'd31,  7'd33,
        7'd34,  7'd36,  7'd37,  7'd39,  7'd41,  7'd42,  7'd44,  7'd45,  7'd47,  7'd48,
        7'd50,  7'd52,  7'd53,  7'd54,  7'd56,  7'd57,  7'd59,  7'd60,  7'd62,  7'd63,
        7'd64,  7'd66,  7'd67,  7'd68,  7'd69,  7'd71,  7'd72,  7'd73,  7'd74,  7'd75,
        7'd77,  7'd78,  7'd79,  7'd80,  7'd81,  7'd82,  7'd83,  7'd84,  7'd85,  7'd86,
        7'd87,  7'd87,  7'd88,  7'd89,  7'd90,  7'd91,  7'd91,  7'd92,  7'd93,  7'd93,
        7'd94,  7'd95,  7'd95,  7'd96,  7'd96,  7'd97,  7'd97,  7'd97,  7'd98,  7'd98,
        7'd98,  7'd99,  7'd99,  7'd99,  7'd99,  7'd100, 7'd100, 7'd100, 7'd100, 7'd100,
        7'd100
    };

    logic [EXT_W-1:0] angle_ext_c;
    logic [IDX_W-1:0] sin_idx_c;
    logic [IDX_W-1:0] cos_idx_c;
    logic             cos_neg_c;
    logic [OUT_W-1:0] sin_c;
    logic [OUT_W-1:0] cos_mag_c;
    logic [OUT_W-1:0] cos_c;

    assign angle_ext_c = EXT_W'(angle);

    // Fold the angle into the first quadrant; beyond 90 deg cosine goes negative.
    always_comb begin
        sin_idx_c = '0;
        cos_idx_c = '0;
        cos_neg_c = 1'b0;
        if (angle_ext_c <= 8'd90) begin
            sin_idx_c = IDX_W'(angle_ext_c);
            cos_idx_c = IDX_W'(8'd90 - angle_ext_c);
        end else begin
            sin_idx_c = IDX_W'(8'd180 - angle_ext_c);
            cos_idx_c = IDX_W'(angle_ext_c - 8'd90);
            cos_neg_c = 1'b1;
        end
    end

    assign sin_c     = OUT_W'(QTAB[sin_idx_c]);
    assign cos_mag_c = OUT_W'(QTAB[cos_idx_c]);
    assign cos_c     = cos_neg_c ? ({OUT_W{1'b0}} - cos_mag_c) : cos_mag_c;

    // Reset loads the angle-0 result and wins over the sampled angle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sin_out <= '0;
            cos_out <= OUT_W'(SCALE);
`ifdef TRIG_VALID_EN
            out_valid <= 1'b0;
`endif
        end else begin
`ifdef TRIG_VALID_EN
            out_valid <= in_valid;
            if (in_valid) begin
                sin_out <= sin_c;
                cos_out <= cos_c;
            end
`else
            sin_out <= sin_c;
            cos_out <= cos_c;
`endif
        end
    end

endmodule

// File: tb/tb_trig_lut_deg.sv
// Self-checking bench for trig_lut_deg against a real-arithmetic sin/cos reference.
module tb_trig_lut_deg;

    localparam real PI = 3.14159265358979323846;

    logic        clk;
    logic        reset;
    logic [6:0]  angle;
    logic [15:0] sin_out;
    logic [15:0] cos_out;
`ifdef TRIG_VALID_EN
    logic        in_valid;
    logic        out_valid;
`endif

    int n_pass;
    int n_total;

    trig_lut_deg dut (
        .clk      (clk),
        .reset    (reset),
`ifdef TRIG_VALID_EN
        .in_valid (in_valid),
        .out_valid(out_valid),
`endif
        .angle    (angle),
        .sin_out  (sin_out),
        .cos_out  (cos_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int round_away(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        else          return -$rtoi(-x + 0.5);
    endfunction

    function automatic logic [15:0] ref_sin(input int deg);
        return 16'(round_away(100.0 * $sin(real'(deg) * PI / 180.0)));
    endfunction

    function automatic logic [15:0] ref_cos(input int deg);
        return 16'(round_away(100.0 * $cos(real'(deg) * PI / 180.0)));
    endfunction

    // Advance one clock and settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        angle = 7'd45;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_total++;
            if ({sin_out, cos_out} !== {16'd0, 16'd100})
                $display("FAIL reset_hold cyc=%0d got sin=%0d cos=%0d want sin=0 cos=100",
                         i, $signed(sin_out), $signed(cos_out));
            else n_pass++;
        end
        reset = 1'b0;
        tick();
        n_total++;
        if ({sin_out, cos_out} !== {16'd71, 16'd71})
            $display("FAIL reset_release got sin=%0d cos=%0d want sin=71 cos=71",
                     $signed(sin_out), $signed(cos_out));
        else n_pass++;
    endtask

    task automatic test_sweep();
        int angs [5] = '{0, 1, 30, 60, 90};
        int es   [5] = '{0, 2, 50, 87, 100};
        int ec   [5] = '{100, 100, 87, 50, 0};
        for (int i = 0; i < 5; i++) begin
            angle = 7'(angs[i]);
            tick();
            n_total++;
            if ({sin_out, cos_out} !== {16'(es[i]), 16'(ec[i])})
                $display("FAIL sweep angle=%0d got sin=%0d cos=%0d want sin=%0d cos=%0d",
                         angs[i], $signed(sin_out), $signed(cos_out), es[i], ec[i]);
            else n_pass++;
        end
    endtask

    task automatic test_negative_cos();
        angle = 7'd120;
        tick();
        n_total++;
        if ({sin_out, cos_out} !== {16'd87, 16'hFFCE})
            $display("FAIL neg_cos_120 got sin=%h cos=%h want sin=0057 cos=ffce", sin_out, cos_out);
        else n_pass++;
        angle = 7'd127;
        tick();
        n_total++;
        if ({sin_out, cos_out} !== {16'd80, 16'hFFC4})
            $display("FAIL neg_cos_127 got sin=%h cos=%h want sin=0050 cos=ffc4", sin_out, cos_out);
        else n_pass++;
    endtask

    task automatic test_exhaustive();
        logic [15:0] es;
        logic [15:0] ec;
        for (int a = 0; a < 128; a++) begin
            angle = 7'(a);
            es = ref_sin(a);
            ec = ref_cos(a);
            tick();
            n_total++;
            if ({sin_out, cos_out} !== {es, ec})
                $display("FAIL exhaustive angle=%0d got sin=%0d cos=%0d want sin=%0d cos=%0d",
                         a, $signed(sin_out), $signed(cos_out), $signed(es), $signed(ec));
            else n_pass++;
            n_total++;
            if ($signed(sin_out) < 0 || $signed(sin_out) > 100 ||
                $signed(cos_out) < -100 || $signed(cos_out) > 100)
                $display("FAIL range angle=%0d got sin=%0d cos=%0d want sin 0..100 cos -100..100",
                         a, $signed(sin_out), $signed(cos_out));
            else n_pass++;
        end
    endtask

    task automatic test_mid_reset();
        for (int a = 96; a <= 104; a++) begin
            angle = 7'(a);
            reset = (a == 100);
            tick();
            n_total++;
            if (a == 100) begin
                if ({sin_out, cos_out} !== {16'd0, 16'd100})
                    $display("FAIL mid_reset angle=%0d got sin=%0d cos=%0d want sin=0 cos=100",
                             a, $signed(sin_out), $signed(cos_out));
                else n_pass++;
            end else begin
                if ({sin_out, cos_out} !== {ref_sin(a), ref_cos(a)})
                    $display("FAIL mid_reset angle=%0d got sin=%0d cos=%0d want sin=%0d cos=%0d",
                             a, $signed(sin_out), $signed(cos_out),
                             $signed(ref_sin(a)), $signed(ref_cos(a)));
                else n_pass++;
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_random();
        int a;
        for (int i = 0; i < 200; i++) begin
            a = int'($urandom_range(0, 127));
            angle = 7'(a);
            tick();
            n_total++;
            if ({sin_out, cos_out} !== {ref_sin(a), ref_cos(a)})
                $display("FAIL random angle=%0d got sin=%0d cos=%0d want sin=%0d cos=%0d",
                         a, $signed(sin_out), $signed(cos_out),
                         $signed(ref_sin(a)), $signed(ref_cos(a)));
            else n_pass++;
        end
    endtask

`ifdef TRIG_VALID_EN
    task automatic test_valid();
        int angs [3] = '{30, 60, 90};
        logic vld [3] = '{1'b1, 1'b0, 1'b1};
        int es   [3] = '{50, 50, 100};
        int ec   [3] = '{87, 87, 0};
        for (int i = 0; i < 3; i++) begin
            angle    = 7'(angs[i]);
            in_valid = vld[i];
            tick();
            n_total++;
            if ({out_valid, sin_out, cos_out} !== {vld[i], 16'(es[i]), 16'(ec[i])})
                $display("FAIL valid step=%0d got v=%0b sin=%0d cos=%0d want v=%0b sin=%0d cos=%0d",
                         i, out_valid, $signed(sin_out), $signed(cos_out), vld[i], es[i], ec[i]);
            else n_pass++;
        end
        in_valid = 1'b1;
    endtask
`endif

    initial begin
        n_pass  = 0;
        n_total = 0;
        reset   = 1'b1;
        angle   = '0;
`ifdef TRIG_VALID_EN
        in_valid = 1'b1;
`endif
        test_reset();
        test_sweep();
        test_negative_cos();
        test_exhaustive();
        test_mid_reset();
        test_random();
`ifdef TRIG_VALID_EN
        test_valid();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
